// File: rtl/mem_cont_rd_tracker.sv
// Continuous-read tracker: keeps a memory read burst open after its data completes
// and acknowledges sequential follow-on reads without a new command being issued.
module mem_cont_rd_tracker #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 12,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                  mem_clk,
  input  logic                  mem_rst,
  input  logic                  mem_mr_xfer_valid,
  input  logic                  mem_mr_xfer_wr_rd,
  input  logic [ADDR_WIDTH-1:0] mem_mr_xfer_addr,
  input  logic [LEN_WIDTH-1:0]  mem_mr_xfer_len,
  input  logic                  xmittr_ack,
  input  logic                  rd_xfer_done,
  input  logic                  cont_rd_en,
  input  logic [TMO_WIDTH-1:0]  cont_rd_tmo,
  output logic                  cont_wr_rd_req,
  output logic                  cont_rd_ack,
  output logic                  cont_rd_term,
  output logic                  cont_rd_active,
  output logic [ADDR_WIDTH-1:0] cont_rd_exp_addr
);

  typedef enum logic [2:0] {
    IDLE,
    RD_BUSY,
    OPEN,
    CONT_ACK,
    CONT_BUSY
  } state_t;

  state_t                 state;
  logic [TMO_WIDTH-1:0]   tmo_cnt;
  logic [ADDR_WIDTH:0]    start_end;
  logic [ADDR_WIDTH:0]    cont_end;
  logic                   rd_req;
  logic                   len_ok;
  logic                   rd_start;
  logic                   match;

  // End address with carry bit; a carry means the burst would wrap the address space.
  function automatic logic [ADDR_WIDTH:0] end_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [LEN_WIDTH-1:0]  len
  );
    return {1'b0, base} + {{(ADDR_WIDTH + 1 - LEN_WIDTH){1'b0}}, len};
  endfunction

  always_comb begin
    start_end = end_addr(mem_mr_xfer_addr, mem_mr_xfer_len);
    cont_end  = end_addr(cont_rd_exp_addr, mem_mr_xfer_len);
    rd_req    = mem_mr_xfer_valid & ~mem_mr_xfer_wr_rd;
    len_ok    = (mem_mr_xfer_len != '0);
    rd_start  = rd_req & xmittr_ack & cont_rd_en;
    match     = (state == OPEN) & rd_req & len_ok & cont_rd_en &
                (mem_mr_xfer_addr == cont_rd_exp_addr) & ~cont_end[ADDR_WIDTH];
    cont_wr_rd_req = match | (state == CONT_ACK);
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      cont_rd_exp_addr <= '0;
      cont_rd_ack      <= 1'b0;
      cont_rd_term     <= 1'b0;
      cont_rd_active   <= 1'b0;
    end else begin
      cont_rd_ack  <= 1'b0;
      cont_rd_term <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            cont_rd_exp_addr <= start_end[ADDR_WIDTH-1:0];
            if (!start_end[ADDR_WIDTH] && len_ok) state <= RD_BUSY;
          end
        end
        RD_BUSY, CONT_BUSY: begin
          if (rd_xfer_done) begin
            state          <= OPEN;
            tmo_cnt        <= '0;
            cont_rd_active <= 1'b1;
          end
        end
        OPEN: begin
          // Disable outranks a match; a match outranks the idle timeout.
          if (!cont_rd_en) begin
            state          <= IDLE;
            cont_rd_term   <= 1'b1;
            cont_rd_active <= 1'b0;
          end else if (match) begin
            state            <= CONT_ACK;
            cont_rd_ack      <= 1'b1;
            cont_rd_exp_addr <= cont_end[ADDR_WIDTH-1:0];
          end else if (mem_mr_xfer_valid || (tmo_cnt == cont_rd_tmo)) begin
            state          <= IDLE;
            cont_rd_term   <= 1'b1;
            cont_rd_active <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CONT_ACK: state <= CONT_BUSY;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cont_rd_tracker.sv
// Directed bench for mem_cont_rd_tracker with hand-computed expectations.
module tb_mem_cont_rd_tracker;

  logic        mem_clk = 1'b0;
  logic        mem_rst = 1'b1;
  logic        mem_mr_xfer_valid = 1'b0;
  logic        mem_mr_xfer_wr_rd = 1'b0;
  logic [31:0] mem_mr_xfer_addr = '0;
  logic [11:0] mem_mr_xfer_len = '0;
  logic        xmittr_ack = 1'b0;
  logic        rd_xfer_done = 1'b0;
  logic        cont_rd_en = 1'b1;
  logic [15:0] cont_rd_tmo = 16'd100;
  logic        cont_wr_rd_req;
  logic        cont_rd_ack;
  logic        cont_rd_term;
  logic        cont_rd_active;
  logic [31:0] cont_rd_exp_addr;

  int checks = 0;
  int failures = 0;

  mem_cont_rd_tracker #(.ADDR_WIDTH(32), .LEN_WIDTH(12), .TMO_WIDTH(16)) dut (
    .mem_clk(mem_clk),
    .mem_rst(mem_rst),
    .mem_mr_xfer_valid(mem_mr_xfer_valid),
    .mem_mr_xfer_wr_rd(mem_mr_xfer_wr_rd),
    .mem_mr_xfer_addr(mem_mr_xfer_addr),
    .mem_mr_xfer_len(mem_mr_xfer_len),
    .xmittr_ack(xmittr_ack),
    .rd_xfer_done(rd_xfer_done),
    .cont_rd_en(cont_rd_en),
    .cont_rd_tmo(cont_rd_tmo),
    .cont_wr_rd_req(cont_wr_rd_req),
    .cont_rd_ack(cont_rd_ack),
    .cont_rd_term(cont_rd_term),
    .cont_rd_active(cont_rd_active),
    .cont_rd_exp_addr(cont_rd_exp_addr)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [11:0] len);
    mem_mr_xfer_valid = 1'b1;
    mem_mr_xfer_wr_rd = wr;
    mem_mr_xfer_addr  = addr;
    mem_mr_xfer_len   = len;
  endtask

  task automatic drop();
    mem_mr_xfer_valid = 1'b0;
    xmittr_ack        = 1'b0;
  endtask

  // Read started by the transmit engine from IDLE, then its data completes -> OPEN.
  task automatic open_burst(input logic [31:0] addr, input logic [11:0] len);
    req(1'b0, addr, len);
    xmittr_ack = 1'b1;
    tick();
    drop();
    rd_xfer_done = 1'b1;
    tick();
    rd_xfer_done = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ack", {31'd0, cont_rd_ack}, 32'd0);
    chk("rst_term", {31'd0, cont_rd_term}, 32'd0);
    chk("rst_active", {31'd0, cont_rd_active}, 32'd0);
    chk("rst_exp", cont_rd_exp_addr, 32'h0);
    chk("rst_req", {31'd0, cont_wr_rd_req}, 32'd0);
    #10 mem_rst = 1'b0;

    // Sequential continuation
    req(1'b0, 32'h1000, 12'd64);
    xmittr_ack = 1'b1;
    chk("idle_req", {31'd0, cont_wr_rd_req}, 32'd0);
    tick();
    drop();
    chk("rdbusy_exp", cont_rd_exp_addr, 32'h1040);
    chk("rdbusy_active", {31'd0, cont_rd_active}, 32'd0);
    rd_xfer_done = 1'b1;
    tick();
    rd_xfer_done = 1'b0;
    chk("open_active", {31'd0, cont_rd_active}, 32'd1);
    req(1'b0, 32'h1040, 12'd32);
    #1 chk("match_req", {31'd0, cont_wr_rd_req}, 32'd1);
    chk("match_noack_yet", {31'd0, cont_rd_ack}, 32'd0);
    tick();
    chk("contack_ack", {31'd0, cont_rd_ack}, 32'd1);
    chk("contack_req", {31'd0, cont_wr_rd_req}, 32'd1);
    chk("contack_exp", cont_rd_exp_addr, 32'h1060);
    tick();
    drop();
    chk("contbusy_ack", {31'd0, cont_rd_ack}, 32'd0);
    chk("contbusy_req", {31'd0, cont_wr_rd_req}, 32'd0);
    chk("contbusy_active", {31'd0, cont_rd_active}, 32'd1);

    // Non-sequential read in OPEN
    rd_xfer_done = 1'b1;
    tick();
    rd_xfer_done = 1'b0;
    req(1'b0, 32'h2000, 12'd16);
    #1 chk("mis_req", {31'd0, cont_wr_rd_req}, 32'd0);
    tick();
    chk("mis_term", {31'd0, cont_rd_term}, 32'd1);
    chk("mis_ack", {31'd0, cont_rd_ack}, 32'd0);
    chk("mis_active", {31'd0, cont_rd_active}, 32'd0);
    chk("mis_idle_req", {31'd0, cont_wr_rd_req}, 32'd0);
    tick();
    drop();
    chk("mis_term_once", {31'd0, cont_rd_term}, 32'd0);

    // Idle timeout with limit 5
    cont_rd_tmo = 16'd5;
    open_burst(32'h3000, 12'd16);
    for (int k = 1; k <= 5; k++) tick();
    chk("tmo_c5_term", {31'd0, cont_rd_term}, 32'd0);
    chk("tmo_c5_active", {31'd0, cont_rd_active}, 32'd1);
    tick();
    chk("tmo_c6_term", {31'd0, cont_rd_term}, 32'd1);
    chk("tmo_c6_active", {31'd0, cont_rd_active}, 32'd0);
    tick();
    chk("tmo_c7_term", {31'd0, cont_rd_term}, 32'd0);

    // Match on the timeout cycle wins
    open_burst(32'h3000, 12'd16);
    for (int k = 1; k <= 5; k++) tick();
    req(1'b0, 32'h3010, 12'd16);
    #1 chk("tmomatch_req", {31'd0, cont_wr_rd_req}, 32'd1);
    tick();
    chk("tmomatch_ack", {31'd0, cont_rd_ack}, 32'd1);
    chk("tmomatch_term", {31'd0, cont_rd_term}, 32'd0);
    chk("tmomatch_exp", cont_rd_exp_addr, 32'h3020);
    tick();
    drop();
    chk("tmomatch_term2", {31'd0, cont_rd_term}, 32'd0);
    chk("tmomatch_active", {31'd0, cont_rd_active}, 32'd1);
    rd_xfer_done = 1'b1;
    tick();
    rd_xfer_done = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    chk("tmo_close_term", {31'd0, cont_rd_term}, 32'd1);
    cont_rd_tmo = 16'd100;
    tick();

    // End address carries out: stays IDLE, rd_xfer_done ignored
    req(1'b0, 32'hFFFF_FFC0, 12'd64);
    xmittr_ack = 1'b1;
    tick();
    drop();
    rd_xfer_done = 1'b1;
    tick();
    rd_xfer_done = 1'b0;
    chk("carry_active", {31'd0, cont_rd_active}, 32'd0);
    req(1'b0, 32'h0, 12'd16);
    #1 chk("carry_next_req", {31'd0, cont_wr_rd_req}, 32'd0);
    tick();
    drop();
    chk("carry_next_ack", {31'd0, cont_rd_ack}, 32'd0);

    // Zero length: stays IDLE
    req(1'b0, 32'h4000, 12'd0);
    xmittr_ack = 1'b1;
    tick();
    drop();
    rd_xfer_done = 1'b1;
    tick();
    rd_xfer_done = 1'b0;
    chk("len0_active", {31'd0, cont_rd_active}, 32'd0);

    // Disable falling together with a match: terminate wins
    open_burst(32'h5000, 12'd32);
    chk("en_open_exp", cont_rd_exp_addr, 32'h5020);
    req(1'b0, 32'h5020, 12'd16);
    cont_rd_en = 1'b0;
    #1 chk("en_req", {31'd0, cont_wr_rd_req}, 32'd0);
    tick();
    drop();
    cont_rd_en = 1'b1;
    chk("en_term", {31'd0, cont_rd_term}, 32'd1);
    chk("en_ack", {31'd0, cont_rd_ack}, 32'd0);

    // Write in OPEN terminates
    open_burst(32'h6000, 12'd16);
    req(1'b1, 32'h6010, 12'd16);
    #1 chk("wr_req", {31'd0, cont_wr_rd_req}, 32'd0);
    tick();
    drop();
    chk("wr_term", {31'd0, cont_rd_term}, 32'd1);
    chk("wr_ack", {31'd0, cont_rd_ack}, 32'd0);

    // Zero limit: terminates on the first OPEN cycle
    cont_rd_tmo = 16'd0;
    open_burst(32'h7000, 12'd16);
    chk("tmo0_term_pre", {31'd0, cont_rd_term}, 32'd0);
    tick();
    chk("tmo0_term", {31'd0, cont_rd_term}, 32'd1);
    cont_rd_tmo = 16'd100;

    // Reset during CONT_ACK
    open_burst(32'h8000, 12'd16);
    req(1'b0, 32'h8010, 12'd16);
    tick();
    drop();
    chk("rstmid_ack_pre", {31'd0, cont_rd_ack}, 32'd1);
    #2 mem_rst = 1'b1;
    #1;
    chk("rstmid_ack", {31'd0, cont_rd_ack}, 32'd0);
    chk("rstmid_active", {31'd0, cont_rd_active}, 32'd0);
    chk("rstmid_exp", cont_rd_exp_addr, 32'h0);
    chk("rstmid_req", {31'd0, cont_wr_rd_req}, 32'd0);
    #3 mem_rst = 1'b0;
    tick();
    chk("rstmid_term", {31'd0, cont_rd_term}, 32'd0);
    tick();
    chk("rstmid_term2", {31'd0, cont_rd_term}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
